// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush sequencer covering load-use, multdiv and taken-branch
//           hazards. Optional macro HAZARD_STATS_EN adds stall/flush counters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_instruction,
  input  logic [31:0] de_instruction,
  input  logic        branch_taken_e,
  input  logic        md_ready,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_de,
  output logic        bubble_de,
  output logic        bubble_em,
  output logic        flush_fd,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam logic [4:0] c_OP_RTYPE = 5'b00000;
  localparam logic [4:0] c_OP_LOAD  = 5'b01000;
  localparam logic [4:0] c_OP_SW    = 5'b00111;
  localparam logic [4:0] c_OP_BNE   = 5'b00010;
  localparam logic [4:0] c_OP_BLT   = 5'b00110;
  localparam logic [4:0] c_OP_JR    = 5'b00100;
  localparam logic [4:0] c_ALU_MUL  = 5'b00110;
  localparam logic [4:0] c_ALU_DIV  = 5'b00111;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MD_WAIT  = 2'd1,
    S_MD_ABORT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;

  logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
  logic [4:0] w_de_op, w_de_rd, w_de_alu;
  logic       w_src_a_vld, w_src_b_vld;
  logic [4:0] w_src_a, w_src_b;
  logic       w_de_load, w_de_md, w_load_use;
  logic       w_unused_bits;

  assign w_fd_op  = fd_instruction[31:27];
  assign w_fd_rd  = fd_instruction[26:22];
  assign w_fd_rs  = fd_instruction[21:17];
  assign w_fd_rt  = fd_instruction[16:12];
  assign w_de_op  = de_instruction[31:27];
  assign w_de_rd  = de_instruction[26:22];
  assign w_de_alu = de_instruction[6:2];
  assign w_unused_bits = ^{fd_instruction[11:0], de_instruction[21:7], de_instruction[1:0]};

  // Which F/D fields are actually read as source registers depends on opcode
  always_comb begin
    w_src_a     = w_fd_rs;
    w_src_a_vld = 1'b1;
    w_src_b     = w_fd_rt;
    w_src_b_vld = 1'b0;
    case (w_fd_op)
      c_OP_RTYPE: w_src_b_vld = 1'b1;
      c_OP_SW, c_OP_BNE, c_OP_BLT: begin
        w_src_a     = w_fd_rd;
        w_src_b     = w_fd_rs;
        w_src_b_vld = 1'b1;
      end
      c_OP_JR: w_src_a = w_fd_rd;
      default: ;
    endcase
  end

  assign w_de_load  = (w_de_op == c_OP_LOAD);
  assign w_de_md    = (w_de_op == c_OP_RTYPE) &&
                      ((w_de_alu == c_ALU_MUL) || (w_de_alu == c_ALU_DIV));
  assign w_load_use = w_de_load && (w_de_rd != 5'd0) &&
                      ((w_src_a_vld && (w_src_a == w_de_rd)) ||
                       (w_src_b_vld && (w_src_b == w_de_rd)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_MD_WAIT) r_cnt <= r_cnt + 1'b1;
      else                      r_cnt <= '0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    stall_pc     = 1'b0;
    stall_fd     = 1'b0;
    stall_de     = 1'b0;
    bubble_de    = 1'b0;
    bubble_em    = 1'b0;
    flush_fd     = 1'b0;
    md_start     = 1'b0;
    md_busy      = 1'b0;
    md_timeout   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (branch_taken_e) begin
            flush_fd  = 1'b1;
            bubble_de = 1'b1;
          end else begin
            if (w_de_md) begin
              md_start     = 1'b1;
              stall_pc     = 1'b1;
              stall_fd     = 1'b1;
              stall_de     = 1'b1;
              bubble_em    = 1'b1;
              w_next_state = S_MD_WAIT;
            end
            // D/E is held during a multdiv start, so no bubble is loaded into it
            if (w_load_use) begin
              stall_pc  = 1'b1;
              stall_fd  = 1'b1;
              bubble_de = !w_de_md;
            end
          end
        end
        S_MD_WAIT: begin
          md_busy = 1'b1;
          if (md_ready) begin
            w_next_state = S_IDLE;
          end else begin
            stall_pc  = 1'b1;
            stall_fd  = 1'b1;
            stall_de  = 1'b1;
            bubble_em = 1'b1;
            if (r_cnt == c_CNT_LAST) w_next_state = S_MD_ABORT;
          end
        end
        S_MD_ABORT: begin
          md_timeout   = 1'b1;
          w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_pc) stall_cycles <= stall_cycles + 32'd1;
      if (flush_fd) flush_count  <= flush_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed self-checking bench; dut uses MD_TIMEOUT=64, dut8 uses 8.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fd_instruction, de_instruction;
  logic        branch_taken_e, md_ready;

  logic sp, sf, sd, bd, be, ff, ms, mb, mt;
  logic sp8, sf8, sd8, bd8, be8, ff8, ms8, mb8, mt8;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, stall_cycles8;
  logic [15:0] flush_count, flush_count8;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP   = 32'd0;
  localparam logic [31:0] LW5   = {5'b01000, 5'd5, 5'd2, 17'd0};
  localparam logic [31:0] LW0   = {5'b01000, 5'd0, 5'd2, 17'd0};
  localparam logic [31:0] ADD5  = {5'b00000, 5'd7, 5'd5, 5'd3, 12'd0};
  localparam logic [31:0] ADD0  = {5'b00000, 5'd7, 5'd0, 5'd3, 12'd0};
  localparam logic [31:0] SW5   = {5'b00111, 5'd5, 5'd2, 17'd0};
  localparam logic [31:0] ADDI  = {5'b00101, 5'd9, 5'd6, 5'd5, 12'd0};
  localparam logic [31:0] MUL   = {5'b00000, 5'd4, 5'd2, 5'd3, 5'd0, 5'b00110, 2'b00};

  // Output vector order: stall_pc stall_fd stall_de bubble_de bubble_em flush_fd md_start md_busy md_timeout
  localparam logic [8:0] E_ZERO  = 9'b000000000;
  localparam logic [8:0] E_LU    = 9'b110100000;
  localparam logic [8:0] E_START = 9'b111010100;
  localparam logic [8:0] E_WAIT  = 9'b111010010;
  localparam logic [8:0] E_READY = 9'b000000010;
  localparam logic [8:0] E_ABORT = 9'b000000001;
  localparam logic [8:0] E_BR    = 9'b000101000;

  logic [8:0] outs, outs8;
  assign outs  = {sp, sf, sd, bd, be, ff, ms, mb, mt};
  assign outs8 = {sp8, sf8, sd8, bd8, be8, ff8, ms8, mb8, mt8};

  pipeline_hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .fd_instruction(fd_instruction), .de_instruction(de_instruction),
    .branch_taken_e(branch_taken_e), .md_ready(md_ready),
    .stall_pc(sp), .stall_fd(sf), .stall_de(sd), .bubble_de(bd), .bubble_em(be),
    .flush_fd(ff), .md_start(ms), .md_busy(mb), .md_timeout(mt)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  pipeline_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(8)) dut8 (
    .clock(clock), .reset(reset),
    .fd_instruction(fd_instruction), .de_instruction(de_instruction),
    .branch_taken_e(branch_taken_e), .md_ready(md_ready),
    .stall_pc(sp8), .stall_fd(sf8), .stall_de(sd8), .bubble_de(bd8), .bubble_em(be8),
    .flush_fd(ff8), .md_start(ms8), .md_busy(mb8), .md_timeout(mt8)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles8), .flush_count(flush_count8)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] fd, input logic [31:0] de, input logic br, input logic rdy);
    fd_instruction = fd;
    de_instruction = de;
    branch_taken_e = br;
    md_ready       = rdy;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(NOP, NOP, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(ADD5, MUL, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (outs !== E_ZERO || outs8 !== E_ZERO) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b/%b exp=%b", i, outs, outs8, E_ZERO);
      end
      tick();
    end
    reset = 1'b0;
    drive(NOP, NOP, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (outs !== E_ZERO) begin
        failures++;
        $display("FAIL nop_idle cyc=%0d got=%b exp=%b", i, outs, E_ZERO);
      end
      tick();
    end
  endtask

  task automatic test_load_use;
    logic [31:0] fds [5];
    logic [31:0] des [5];
    logic [8:0]  exps [5];
    fds = '{ADD5, ADD5, ADD0, SW5, ADDI};
    des = '{LW5, NOP, LW0, LW5, LW5};
    exps = '{E_LU, E_ZERO, E_ZERO, E_LU, E_ZERO};
    for (int i = 0; i < 5; i++) begin
      drive(fds[i], des[i], 1'b0, 1'b0);
      @(negedge clock);
      checks++;
      if (outs !== exps[i]) begin
        failures++;
        $display("FAIL load_use vec=%0d got=%b exp=%b", i, outs, exps[i]);
      end
      tick();
    end
    drive(NOP, NOP, 1'b0, 1'b0);
  endtask

  task automatic test_multdiv_normal;
    logic [8:0] e;
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      drive(ADD5, (c <= 17) ? MUL : NOP, (c == 5), (c == 17));
      e = (c == 0) ? E_START : (c < 17) ? E_WAIT : (c == 17) ? E_READY : E_ZERO;
      @(negedge clock);
      checks++;
      if (outs !== e) begin
        failures++;
        $display("FAIL md_normal cyc=%0d got=%b exp=%b", c, outs, e);
      end
      tick();
    end
    drive(NOP, NOP, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    logic [8:0] e;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      drive(NOP, (c <= 9) ? MUL : NOP, 1'b0, 1'b0);
      e = (c == 0) ? E_START : (c <= 8) ? E_WAIT : (c == 9) ? E_ABORT : E_ZERO;
      @(negedge clock);
      checks++;
      if (outs8 !== e) begin
        failures++;
        $display("FAIL md_timeout cyc=%0d got=%b exp=%b", c, outs8, e);
      end
      tick();
    end
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      drive(NOP, (c <= 8) ? MUL : NOP, 1'b0, (c == 8));
      e = (c == 0) ? E_START : (c <= 7) ? E_WAIT : (c == 8) ? E_READY : E_ZERO;
      @(negedge clock);
      checks++;
      if (outs8 !== e) begin
        failures++;
        $display("FAIL md_ready_on_last cyc=%0d got=%b exp=%b", c, outs8, e);
      end
      tick();
    end
    drive(NOP, NOP, 1'b0, 1'b0);
  endtask

  task automatic test_branch;
    do_reset();
    drive(ADD5, LW5, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (outs !== E_BR) begin
      failures++;
      $display("FAIL branch_over_loaduse got=%b exp=%b", outs, E_BR);
    end
    tick();
    drive(NOP, MUL, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (outs !== E_BR) begin
      failures++;
      $display("FAIL branch_over_md got=%b exp=%b", outs, E_BR);
    end
    tick();
    drive(NOP, NOP, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (outs !== E_ZERO) begin
      failures++;
      $display("FAIL after_branch got=%b exp=%b", outs, E_ZERO);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] des [8];
    logic        rdys [8];
    logic [8:0]  exps [8];
    des  = '{MUL, MUL, MUL, MUL, MUL, MUL, MUL, NOP};
    rdys = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exps = '{E_START, E_WAIT, E_WAIT, E_READY, E_START, E_WAIT, E_READY, E_ZERO};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(NOP, des[c], 1'b0, rdys[c]);
      @(negedge clock);
      checks++;
      if (outs !== exps[c]) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, outs, exps[c]);
      end
      tick();
    end
    drive(NOP, NOP, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op;
    logic [8:0] e;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      drive(NOP, MUL, 1'b0, 1'b0);
      @(negedge clock);
      checks++;
      e = (c == 0) ? E_START : E_WAIT;
      if (outs8 !== e) begin
        failures++;
        $display("FAIL mid_op_pre cyc=%0d got=%b exp=%b", c, outs8, e);
      end
      tick();
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (outs8 !== E_ZERO) begin
      failures++;
      $display("FAIL mid_op_reset_cycle got=%b exp=%b", outs8, E_ZERO);
    end
    tick();
    reset = 1'b0;
    drive(NOP, NOP, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++;
      if (outs8 !== E_ZERO) begin
        failures++;
        $display("FAIL mid_op_after cyc=%0d got=%b exp=%b", c, outs8, E_ZERO);
      end
      tick();
    end
    for (int c = 0; c <= 9; c++) begin
      drive(NOP, MUL, 1'b0, 1'b0);
      @(negedge clock);
      if (c == 8) begin
        checks++;
        if (outs8 !== E_WAIT) begin
          failures++;
          $display("FAIL restart_wait8 got=%b exp=%b", outs8, E_WAIT);
        end
      end
      if (c == 9) begin
        checks++;
        if (outs8 !== E_ABORT) begin
          failures++;
          $display("FAIL restart_abort9 got=%b exp=%b", outs8, E_ABORT);
        end
      end
      tick();
    end
    drive(NOP, NOP, 1'b0, 1'b0);
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats;
    do_reset();
    drive(ADD5, LW5, 1'b0, 1'b0);
    tick();
    drive(NOP, NOP, 1'b0, 1'b0);
    tick();
    for (int c = 0; c <= 17; c++) begin
      drive(NOP, MUL, 1'b0, (c == 17));
      tick();
    end
    drive(NOP, NOP, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (stall_cycles !== 32'd18 || flush_count !== 16'd0) begin
      failures++;
      $display("FAIL stats_stall got=%0d/%0d exp=18/0", stall_cycles, flush_count);
    end
    tick();
    drive(NOP, NOP, 1'b1, 1'b0);
    tick();
    drive(NOP, NOP, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (flush_count !== 16'd1 || stall_cycles !== 32'd18) begin
      failures++;
      $display("FAIL stats_flush got=%0d/%0d exp=1/18", flush_count, stall_cycles);
    end
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(NOP, NOP, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_multdiv_normal();
    test_timeout();
    test_branch();
    test_back_to_back();
    test_reset_mid_op();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
